// File: rtl/mem_access_ctrl_pkg.sv
// Shared types for the MAR/MDR memory access sequencer: state encoding,
// op codes, default widths and the state-to-strobe decode.
package mem_access_ctrl_pkg;

  localparam int DEFAULT_ADDR_W = 9;
  localparam int DEFAULT_DATA_W = 32;

  localparam logic OP_LOAD  = 1'b0;
  localparam logic OP_STORE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MAR     = 3'd1,
    ST_WAIT    = 3'd2,
    ST_LD      = 3'd3,
    ST_DONE_LD = 3'd4,
    ST_SD      = 3'd5,
    ST_WR      = 3'd6,
    ST_DONE_ST = 3'd7
  } state_t;

  typedef struct packed {
    logic mar_en;
    logic mdr_en;
    logic rd_mem;
    logic write;
    logic done;
    logic busy;
  } strobe_t;

  // Strobe pattern that must be visible while the FSM sits in a state.
  // Write never shares a state with MDR load or memory read select.
  function automatic strobe_t decode_strobes(input state_t st);
    strobe_t s;
    s = '0;
    case (st)
      ST_IDLE: s = '0;
      ST_MAR: begin
        s.mar_en = 1'b1;
        s.busy   = 1'b1;
      end
      ST_WAIT: s.busy = 1'b1;
      ST_LD: begin
        s.mdr_en = 1'b1;
        s.rd_mem = 1'b1;
        s.busy   = 1'b1;
      end
      ST_DONE_LD, ST_DONE_ST: begin
        s.done = 1'b1;
        s.busy = 1'b1;
      end
      ST_SD: begin
        s.mdr_en = 1'b1;
        s.busy   = 1'b1;
      end
      ST_WR: begin
        s.write = 1'b1;
        s.busy  = 1'b1;
      end
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_wait_counter.sv
// Two-bit down-counter that times the extra read-wait cycles of a load.
module mem_wait_counter (
  input  logic       clk,
  input  logic       clear,
  input  logic       load,
  input  logic [1:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [1:0] cnt_q;
  logic [1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != 2'd0)) begin
      cnt_d = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      cnt_q <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == 2'd0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Initiator-side sequencer driving bus value and MAR/MDR/memory strobes for
// one load or store per request; every output comes straight from a flop.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W    = DEFAULT_ADDR_W,
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int READ_WAIT = 0
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              req,
  input  logic              op_store,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] MDR_q,
  output logic [DATA_W-1:0] bus_out,
  output logic              MAR_enable,
  output logic              MDR_enable,
  output logic              Read_from_mem,
  output logic              Write,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output state_t            state_dbg
);

  localparam logic [1:0] WAIT_LOAD = (READ_WAIT > 0) ? 2'(READ_WAIT - 1) : 2'd0;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              store_q, store_d;
  logic [DATA_W-1:0] bus_q, bus_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  strobe_t           strb_q, strb_d;

  logic cnt_load;
  logic cnt_dec;
  logic cnt_zero;

  mem_wait_counter u_wait_cnt (
    .clk      (clk),
    .clear    (clear),
    .load     (cnt_load),
    .load_val (WAIT_LOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Handshake: req/op_store/addr/wdata are sampled only on an edge where the
  // FSM is in IDLE; busy is high from that edge until DONE is left, and any
  // req seen while busy is dropped, never queued.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    store_d  = store_q;
    rdata_d  = rdata_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          addr_d  = addr;
          wdata_d = wdata;
          store_d = op_store;
          state_d = ST_MAR;
        end
      end
      ST_MAR: begin
        if (store_q == OP_STORE) begin
          state_d = ST_SD;
        end else if (READ_WAIT > 0) begin
          state_d  = ST_WAIT;
          cnt_load = 1'b1;
        end else begin
          state_d = ST_LD;
        end
      end
      ST_WAIT: begin
        if (cnt_zero) begin
          state_d = ST_LD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_LD:      state_d = ST_DONE_LD;
      ST_DONE_LD: begin
        rdata_d = MDR_q;
        state_d = ST_IDLE;
      end
      ST_SD:      state_d = ST_WR;
      ST_WR:      state_d = ST_DONE_ST;
      ST_DONE_ST: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    // Outputs are computed for the state being entered so they sit in flops.
    strb_d = decode_strobes(state_d);
    case (state_d)
      ST_MAR, ST_WAIT, ST_LD: bus_d = DATA_W'(addr_d);
      ST_SD, ST_WR:           bus_d = wdata_d;
      default:                bus_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      store_q <= OP_LOAD;
      bus_q   <= '0;
      rdata_q <= '0;
      strb_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      store_q <= store_d;
      bus_q   <= bus_d;
      rdata_q <= rdata_d;
      strb_q  <= strb_d;
    end
  end

  assign bus_out       = bus_q;
  assign MAR_enable    = strb_q.mar_en;
  assign MDR_enable    = strb_q.mdr_en;
  assign Read_from_mem = strb_q.rd_mem;
  assign Write         = strb_q.write;
  assign busy          = strb_q.busy;
  assign done          = strb_q.done;
  assign rdata         = rdata_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl with a MAR/MDR/memory environment around two
// instances (READ_WAIT=0 and READ_WAIT=2) and a per-cycle expected trace.
`timescale 1ns/1ps
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  localparam int AW = 9;
  localparam int DW = 32;

  typedef struct packed {
    logic          mar;
    logic          mdr;
    logic          rfm;
    logic          wr;
    logic          dn;
    logic          chk_bus;
    logic [DW-1:0] bus;
    logic [DW-1:0] rd;
  } trace_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic clear = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          req      [2];
  logic          op_store [2];
  logic [AW-1:0] addr     [2];
  logic [DW-1:0] wdata    [2];
  logic [DW-1:0] bus_out  [2];
  logic          mar_en   [2];
  logic          mdr_en   [2];
  logic          rfm      [2];
  logic          wr       [2];
  logic          busy     [2];
  logic          done     [2];
  logic [DW-1:0] rdata    [2];
  state_t        st_dbg   [2];

  logic [DW-1:0] mem     [512];
  logic [AW-1:0] mar_reg [2];
  logic [DW-1:0] mdr_reg [2];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;

  mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .READ_WAIT(0)) u_dut0 (
    .clk(clk), .clear(clear), .req(req[0]), .op_store(op_store[0]),
    .addr(addr[0]), .wdata(wdata[0]), .MDR_q(mdr_reg[0]), .bus_out(bus_out[0]),
    .MAR_enable(mar_en[0]), .MDR_enable(mdr_en[0]), .Read_from_mem(rfm[0]),
    .Write(wr[0]), .busy(busy[0]), .done(done[0]), .rdata(rdata[0]),
    .state_dbg(st_dbg[0])
  );

  mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .READ_WAIT(2)) u_dut1 (
    .clk(clk), .clear(clear), .req(req[1]), .op_store(op_store[1]),
    .addr(addr[1]), .wdata(wdata[1]), .MDR_q(mdr_reg[1]), .bus_out(bus_out[1]),
    .MAR_enable(mar_en[1]), .MDR_enable(mdr_en[1]), .Read_from_mem(rfm[1]),
    .Write(wr[1]), .busy(busy[1]), .done(done[1]), .rdata(rdata[1]),
    .state_dbg(st_dbg[1])
  );

  // MAR, MDR and memory as the datapath would behave.
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    for (int i = 0; i < 2; i++) begin
      if (mar_en[i]) mar_reg[i] <= bus_out[i][AW-1:0];
      if (mdr_en[i]) mdr_reg[i] <= rfm[i] ? mem[mar_reg[i]] : bus_out[i];
      if (wr[i])     mem[mar_reg[i]] <= mdr_reg[i];
    end
  end

  // ---------------- scoreboard ----------------
  trace_t        tq [2][$];
  logic [DW-1:0] last_rd [2];
  logic [DW-1:0] sb [16];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input int i, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst%0d t=%0t actual=%h expected=%h", nm, i, $time, act, exp);
    end
  endtask

  task automatic chk_zero(input int i, input string tag);
    chk({tag, "_strobes"}, i,
        DW'({mar_en[i], mdr_en[i], rfm[i], wr[i], done[i], busy[i]}), '0);
    chk({tag, "_bus"}, i, bus_out[i], '0);
    chk({tag, "_rdata"}, i, rdata[i], '0);
  endtask

  // Monitor: one trace entry per busy cycle, strobes quiet otherwise.
  initial begin : monitor
    logic          pend     [2];
    logic [DW-1:0] pend_val [2];
    trace_t        e;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    pend_val[0] = '0;
    pend_val[1] = '0;
    forever begin
      @(negedge clk);
      if (clear) begin
        for (int i = 0; i < 2; i++) begin
          tq[i].delete();
          pend[i] = 1'b0;
        end
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (pend[i]) begin
            chk("rdata", i, rdata[i], pend_val[i]);
            pend[i] = 1'b0;
          end
          if (tq[i].size() > 0) begin
            e = tq[i].pop_front();
            chk("strobes", i, DW'({mar_en[i], mdr_en[i], rfm[i], wr[i], done[i]}),
                DW'({e.mar, e.mdr, e.rfm, e.wr, e.dn}));
            if (e.chk_bus) chk("bus_out", i, bus_out[i], e.bus);
            if (e.dn) begin
              pend[i] = 1'b1;
              pend_val[i] = e.rd;
            end
          end else begin
            chk("idle_strobes", i, DW'({mar_en[i], mdr_en[i], rfm[i], wr[i], done[i]}), '0);
          end
          chk("write_mdr_excl", i, DW'(wr[i] & mdr_en[i]), '0);
          chk("write_rfm_excl", i, DW'(wr[i] & rfm[i]), '0);
          chk("mar_only_in_mar", i, DW'(mar_en[i]), DW'(st_dbg[i] == ST_MAR));
          chk("busy_vs_idle", i, DW'(busy[i]), DW'(st_dbg[i] != ST_IDLE));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_trace(input int i, input logic st, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd);
    trace_t e;
    logic [DW-1:0] abus;
    int rw;
    abus = DW'(a);
    rw = (i == 0) ? 0 : 2;
    e = '0; e.mar = 1'b1; e.chk_bus = 1'b1; e.bus = abus; tq[i].push_back(e);
    if (st == OP_LOAD) begin
      for (int k = 0; k < rw; k++) begin
        e = '0; e.chk_bus = 1'b1; e.bus = abus; tq[i].push_back(e);
      end
      e = '0; e.mdr = 1'b1; e.rfm = 1'b1; tq[i].push_back(e);
      e = '0; e.dn = 1'b1; e.rd = exp_rd; tq[i].push_back(e);
      last_rd[i] = exp_rd;
    end else begin
      e = '0; e.mdr = 1'b1; e.chk_bus = 1'b1; e.bus = wd; tq[i].push_back(e);
      e = '0; e.wr = 1'b1; e.chk_bus = 1'b1; e.bus = wd; tq[i].push_back(e);
      e = '0; e.dn = 1'b1; e.rd = last_rd[i]; tq[i].push_back(e);
    end
  endtask

  // Called at posedge+1; returns once the previous request's trace is consumed.
  task automatic wait_idle(input int i);
    int n;
    n = 0;
    while (tq[i].size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 200) begin
      failures++;
      $display("FAIL wait_idle inst%0d timeout pending=%0d required=0", i, tq[i].size());
      tq[i].delete();
    end
  endtask

  task automatic issue(input int i, input logic st, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd,
                       input bit hold);
    wait_idle(i);
    req[i] = 1'b1;
    op_store[i] = st;
    addr[i] = a;
    wdata[i] = wd;
    @(posedge clk); #1;
    if (!hold) req[i] = 1'b0;
    push_trace(i, st, a, wd, exp_rd);
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_en = 1'b1;
    pl_addr = a;
    pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin : stimulus
    logic          st;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0;
      op_store[i] = 1'b0;
      addr[i] = '0;
      wdata[i] = '0;
      last_rd[i] = '0;
    end
    @(posedge clk); #1;
    preload(9'h054, 32'h0000_0097);
    preload(9'h034, 32'h0000_0025);
    preload(9'h010, 32'h0000_1234);
    preload(9'h020, 32'h0000_0055);
    for (int k = 0; k < 16; k++) begin
      sb[k] = 32'h1000_0000 + k * 32'h0101;
      preload(AW'(k), sb[k]);
    end
    chk_zero(0, "reset");
    chk_zero(1, "reset");
    clear = 1'b0;

    // Basic load and store/readback, READ_WAIT=0.
    issue(0, OP_LOAD,  9'h054, 32'h0,  32'h97, 1'b0);
    issue(0, OP_STORE, 9'h034, 32'hB6, 32'h0,  1'b0);
    issue(0, OP_LOAD,  9'h034, 32'h0,  32'hB6, 1'b0);

    // READ_WAIT=2: two quiet cycles between MAR and LD.
    issue(1, OP_LOAD, 9'h010, 32'h0, 32'h1234, 1'b0);

    // req held high across a store then a load.
    issue(0, OP_STORE, 9'h040, 32'h77, 32'h0, 1'b1);
    op_store[0] = OP_LOAD;
    addr[0] = 9'h040;
    wdata[0] = 32'hFFFF_FFFF;
    repeat (5) @(posedge clk);
    #1;
    req[0] = 1'b0;
    push_trace(0, OP_LOAD, 9'h040, 32'h0, 32'h77);

    // req pulses while busy are ignored.
    issue(0, OP_LOAD, 9'h054, 32'h0, 32'h97, 1'b0);
    req[0] = 1'b1;
    op_store[0] = OP_STORE;
    addr[0] = 9'h054;
    wdata[0] = 32'hDEAD;
    repeat (2) @(posedge clk);
    #1;
    req[0] = 1'b0;
    issue(0, OP_LOAD, 9'h054, 32'h0, 32'h97, 1'b0);

    // clear during SD of a store: immediate quiet outputs, no write.
    issue(0, OP_STORE, 9'h020, 32'hAA, 32'h0, 1'b0);
    @(posedge clk);
    #2;
    clear = 1'b1;
    #1;
    chk_zero(0, "abort");
    @(negedge clk);
    @(posedge clk); #1;
    clear = 1'b0;
    last_rd[0] = '0;
    last_rd[1] = '0;
    issue(0, OP_LOAD, 9'h020, 32'h0, 32'h55, 1'b0);

    // Random load/store mix over a small preloaded window.
    for (int n = 0; n < 200; n++) begin
      st = 1'($urandom_range(0, 1));
      a = AW'($urandom_range(0, 15));
      wd = $urandom;
      if (st == OP_STORE) begin
        issue(0, OP_STORE, a, wd, 32'h0, 1'b0);
        sb[a[3:0]] = wd;
      end else begin
        issue(0, OP_LOAD, a, 32'h0, sb[a[3:0]], 1'b0);
      end
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    wait_idle(0);
    wait_idle(1);
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
